// File: rtl/id_ex_bubble_ctrl.sv
// ID/EX control-pipeline register with load-use hazard detection, multi-cycle
// bubble insertion, flush/hold handling and a saturating bubble counter.
module id_ex_bubble_ctrl #(
  parameter int                 CTRL_W       = 13,
  parameter int                 MEMRD_BIT    = 2,
  parameter int                 REG_AW       = 5,
  parameter int                 STALL_CYCLES = 1,
  parameter logic [CTRL_W-1:0]  BUBBLE_VAL   = '0,
  parameter int                 CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              flush,
  input  logic              hold,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rd,
  output logic              stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic {ST_RUN, ST_STALL} state_t;

  state_t              state, state_nxt;
  logic [3:0]          rem, rem_nxt;
  logic [CTRL_W-1:0]   ex_ctrl_p1;
  logic                vld_p1;
  logic [REG_AW-1:0]   ex_rd_p1;
  logic [CNT_W-1:0]    cnt_q;
  logic                haz;
  logic                load_bubble;
  logic                load_id;
  logic                cnt_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Load in EX writing a nonzero register that the ID instruction reads
  assign haz = vld_p1 & ex_ctrl_p1[MEMRD_BIT] & (ex_rd_p1 != '0) & id_valid &
               ((ex_rd_p1 == id_rs) | (ex_rd_p1 == id_rt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      rem   <= 4'd0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rem_nxt     = rem;
    load_bubble = 1'b0;
    load_id     = 1'b0;
    cnt_inc     = 1'b0;
    if (flush) begin
      state_nxt   = ST_RUN;
      rem_nxt     = 4'd0;
      load_bubble = 1'b1;
    end else if (hold) begin
      // everything freezes, including a pending bubble sequence
    end else if (state == ST_STALL) begin
      load_bubble = 1'b1;
      cnt_inc     = 1'b1;
      rem_nxt     = rem - 4'd1;
      if (rem <= 4'd1) state_nxt = ST_RUN;
    end else if (haz) begin
      load_bubble = 1'b1;
      cnt_inc     = 1'b1;
      if (STALL_CYCLES > 1) begin
        state_nxt = ST_STALL;
        rem_nxt   = 4'(STALL_CYCLES - 1);
      end
    end else begin
      load_id = 1'b1;
    end
  end

  always_comb begin
    stall = ~flush & (hold | (state == ST_STALL) | haz);
  end

  // ID -> EX stage boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_p1 <= BUBBLE_VAL;
      vld_p1     <= 1'b0;
      ex_rd_p1   <= '0;
      cnt_q      <= '0;
    end else begin
      if (load_bubble) begin
        ex_ctrl_p1 <= BUBBLE_VAL;
        vld_p1     <= 1'b0;
        ex_rd_p1   <= '0;
      end else if (load_id) begin
        ex_ctrl_p1 <= id_ctrl;
        vld_p1     <= id_valid;
        ex_rd_p1   <= id_rd;
      end
      if (cnt_inc) cnt_q <= sat_inc(cnt_q);
    end
  end

  assign ex_ctrl    = ex_ctrl_p1;
  assign ex_valid   = vld_p1;
  assign ex_rd      = ex_rd_p1;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_bubble_ctrl.sv
// Directed scoreboard bench: dut_a (1 bubble, 2-bit counter) and dut_b (3 bubbles)
// share inputs; each vector names which instance it expects a response from.
module tb_id_ex_bubble_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] id_ctrl;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        flush, hold;

  logic [12:0] a_ctrl, b_ctrl;
  logic        a_vld, b_vld, a_stall, b_stall;
  logic [4:0]  a_rd, b_rd;
  logic [1:0]  a_cnt;
  logic [15:0] b_cnt;

  always #5 clk = ~clk;

  id_ex_bubble_ctrl #(.CTRL_W(13), .MEMRD_BIT(2), .REG_AW(5), .STALL_CYCLES(1),
                      .BUBBLE_VAL(13'h0), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush), .hold(hold),
    .ex_ctrl(a_ctrl), .ex_valid(a_vld), .ex_rd(a_rd), .stall(a_stall),
    .bubble_cnt(a_cnt));

  id_ex_bubble_ctrl #(.CTRL_W(13), .MEMRD_BIT(2), .REG_AW(5), .STALL_CYCLES(3),
                      .BUBBLE_VAL(13'h0), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush), .hold(hold),
    .ex_ctrl(b_ctrl), .ex_valid(b_vld), .ex_rd(b_rd), .stall(b_stall),
    .bubble_cnt(b_cnt));

  typedef struct {
    int          id;
    logic        sel;
    logic        stall;
    logic [12:0] ctrl;
    logic        vld;
    logic [4:0]  rd;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec_no   = 0;

  localparam logic [12:0] LD  = 13'h0004;
  localparam logic [12:0] ALU = 13'h1AAA;
  localparam logic [12:0] OTH = 13'h0101;

  task automatic chk(input string nm, input int id, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec%0d: got %h want %h", nm, id, act, exp);
    end
  endtask

  // Monitor: the DUT presents a full output set every cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.sel) begin
        chk("stall", e.id, {15'd0, b_stall}, {15'd0, e.stall});
        chk("ex_ctrl", e.id, {3'd0, b_ctrl}, {3'd0, e.ctrl});
        chk("ex_valid", e.id, {15'd0, b_vld}, {15'd0, e.vld});
        chk("ex_rd", e.id, {11'd0, b_rd}, {11'd0, e.rd});
        chk("bubble_cnt", e.id, b_cnt, e.cnt);
      end else begin
        chk("stall", e.id, {15'd0, a_stall}, {15'd0, e.stall});
        chk("ex_ctrl", e.id, {3'd0, a_ctrl}, {3'd0, e.ctrl});
        chk("ex_valid", e.id, {15'd0, a_vld}, {15'd0, e.vld});
        chk("ex_rd", e.id, {11'd0, a_rd}, {11'd0, e.rd});
        chk("bubble_cnt", e.id, {14'd0, a_cnt}, e.cnt);
      end
    end
  end

  // Drive one cycle of inputs and queue what the selected DUT must show mid-cycle:
  // registered outputs from the previous edge, stall for these inputs.
  task automatic cyc(input logic sel, input logic rstn, input logic [12:0] c,
                     input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic fl, input logic hd,
                     input logic e_stall, input logic [12:0] e_ctrl,
                     input logic e_vld, input logic [4:0] e_rd, input logic [15:0] e_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rstn; id_ctrl = c; id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    flush = fl; hold = hd;
    vec_no++;
    e.id = vec_no; e.sel = sel; e.stall = e_stall; e.ctrl = e_ctrl;
    e.vld = e_vld; e.rd = e_rd; e.cnt = e_cnt;
    sb.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; id_ctrl = '0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
    flush = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // pass-through, then asynchronous reset mid-stream (dut_b)
    //  sel rst ctrl v rs rt rd fl hd | stall ctrl vld rd cnt
    cyc(1, 1, ALU, 1, 1, 2, 7, 0, 0,   0, 13'h0, 0, 0, 0);
    cyc(1, 1, ALU, 1, 1, 2, 7, 0, 0,   0, ALU,   1, 7, 0);
    cyc(1, 1, ALU, 1, 1, 2, 7, 0, 0,   0, ALU,   1, 7, 0);
    cyc(1, 0, ALU, 1, 1, 2, 7, 0, 0,   0, 13'h0, 0, 0, 0);
    cyc(1, 1, 13'h0, 0, 0, 0, 0, 0, 0, 0, 13'h0, 0, 0, 0);

    // no false hazards
    cyc(1, 1, LD,  1, 0, 0, 0, 0, 0,   0, 13'h0, 0, 0, 0);
    cyc(1, 1, ALU, 1, 0, 0, 3, 0, 0,   0, LD,    1, 0, 0);
    cyc(1, 1, ALU, 1, 0, 0, 5, 0, 0,   0, ALU,   1, 3, 0);
    cyc(1, 1, OTH, 1, 0, 5, 6, 0, 0,   0, ALU,   1, 5, 0);
    cyc(1, 1, LD,  1, 0, 0, 5, 0, 0,   0, OTH,   1, 6, 0);
    cyc(1, 1, OTH, 0, 5, 5, 9, 0, 0,   0, LD,    1, 5, 0);

    // load-use with 3 bubbles, hold for 2 cycles during the 2nd bubble
    cyc(1, 1, LD,  1, 0, 0, 5, 0, 0,   0, OTH,   0, 9, 0);
    cyc(1, 1, ALU, 1, 5, 0, 8, 0, 0,   1, LD,    1, 5, 0);
    cyc(1, 1, ALU, 1, 5, 0, 8, 0, 1,   1, 13'h0, 0, 0, 1);
    cyc(1, 1, ALU, 1, 5, 0, 8, 0, 1,   1, 13'h0, 0, 0, 1);
    cyc(1, 1, ALU, 1, 5, 0, 8, 0, 0,   1, 13'h0, 0, 0, 1);
    cyc(1, 1, ALU, 1, 5, 0, 8, 0, 0,   1, 13'h0, 0, 0, 2);
    cyc(1, 1, ALU, 1, 5, 0, 8, 0, 0,   0, 13'h0, 0, 0, 3);
    cyc(1, 1, 13'h0, 0, 0, 0, 0, 0, 0, 0, ALU,   1, 8, 3);

    // flush in the same cycle as a hazard
    cyc(1, 1, LD,  1, 0, 0, 5, 0, 0,   0, 13'h0, 0, 0, 3);
    cyc(1, 1, ALU, 1, 5, 0, 8, 1, 0,   0, LD,    1, 5, 3);
    cyc(1, 1, OTH, 1, 0, 5, 4, 0, 0,   0, 13'h0, 0, 0, 3);
    cyc(1, 1, 13'h0, 0, 0, 0, 0, 0, 0, 0, OTH,   1, 4, 3);

    // dut_a: reset, single-bubble load-use, then counter saturation
    cyc(0, 0, 13'h0, 0, 0, 0, 0, 0, 0, 0, 13'h0, 0, 0, 0);
    cyc(0, 1, 13'h0, 0, 0, 0, 0, 0, 0, 0, 13'h0, 0, 0, 0);
    cyc(0, 1, LD,  1, 0, 0, 5, 0, 0,   0, 13'h0, 0, 0, 0);
    cyc(0, 1, ALU, 1, 5, 0, 8, 0, 0,   1, LD,    1, 5, 0);
    cyc(0, 1, ALU, 1, 5, 0, 8, 0, 0,   0, 13'h0, 0, 0, 1);
    cyc(0, 1, LD,  1, 0, 0, 5, 0, 0,   0, ALU,   1, 8, 1);
    cyc(0, 1, ALU, 1, 0, 5, 8, 0, 0,   1, LD,    1, 5, 1);
    cyc(0, 1, ALU, 1, 0, 5, 8, 0, 0,   0, 13'h0, 0, 0, 2);
    cyc(0, 1, LD,  1, 0, 0, 5, 0, 0,   0, ALU,   1, 8, 2);
    cyc(0, 1, ALU, 1, 5, 0, 8, 0, 0,   1, LD,    1, 5, 2);
    cyc(0, 1, ALU, 1, 5, 0, 8, 0, 0,   0, 13'h0, 0, 0, 3);
    cyc(0, 1, LD,  1, 0, 0, 5, 0, 0,   0, ALU,   1, 8, 3);
    cyc(0, 1, ALU, 1, 5, 0, 8, 0, 0,   1, LD,    1, 5, 3);
    cyc(0, 1, ALU, 1, 5, 0, 8, 0, 0,   0, 13'h0, 0, 0, 3);
    cyc(0, 1, LD,  1, 0, 0, 5, 0, 0,   0, ALU,   1, 8, 3);
    cyc(0, 1, ALU, 1, 5, 0, 8, 0, 0,   1, LD,    1, 5, 3);
    cyc(0, 1, ALU, 1, 5, 0, 8, 0, 0,   0, 13'h0, 0, 0, 3);
    cyc(0, 1, 13'h0, 0, 0, 0, 0, 0, 0, 0, ALU,   1, 8, 3);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
